multi_button_debouncer: RTL and testbench

//   N-channel debouncer for push-buttons and switches. Successor to the single-channel debouncer.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 114 +++++++++++
 rtl/multi_button_debouncer.sv | 34 +++
 tb/tb_multi_button_debouncer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared timing defaults and counter sizing helper for the button debouncer.
// Imported by debounce_channel and multi_button_debouncer.
package debounce_pkg;

   localparam int DB_TIME_DEFAULT     = 100000;
   localparam int HOLD_TIME_DEFAULT   = 50000000;
   localparam int REPEAT_TIME_DEFAULT = 10000000;

   // Number of bits needed to hold every value from 0 up to max_val.
   function automatic int clog2_cnt(input int unsigned max_val);
      int w;
      w = 1;
      while ((longint'(1) << w) <= longint'(max_val)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stable-time counter, level and edge pulses.
// With AUTO_REPEAT_EN defined, a hold counter adds auto-repeat press pulses while held.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_TIME = DB_TIME_DEFAULT,
   parameter int HOLD_TIME     = HOLD_TIME_DEFAULT,
   parameter int REPEAT_TIME   = REPEAT_TIME_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int               CNT_W   = clog2_cnt(DEBOUNCE_TIME);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             commit, rise, fall;
   logic             rpt_fire;

   // Any return of s2 to the current level restarts the stable-time count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      commit  = 1'b0;
      if (s2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
         commit  = 1'b1;
         cnt_d   = '0;
         level_d = s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign rise = commit & s2_q;
   assign fall = commit & ~s2_q;

`ifdef AUTO_REPEAT_EN
   localparam int HOLD_MAX = (HOLD_TIME > REPEAT_TIME) ? HOLD_TIME : REPEAT_TIME;
   localparam int HOLD_W   = clog2_cnt(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIME - 1);
   localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_TIME - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              repeat_q, repeat_d;

   // The release edge clears the hold state so no repeat can fire alongside release_pulse.
   always_comb begin
      hold_d   = hold_q;
      repeat_d = repeat_q;
      rpt_fire = 1'b0;
      if (!level_q || fall) begin
         hold_d   = '0;
         repeat_d = 1'b0;
      end else if (hold_q == (repeat_q ? RPT_LAST : HOLD_LAST)) begin
         rpt_fire = 1'b1;
         hold_d   = '0;
         repeat_d = 1'b1;
      end else begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q   <= '0;
         repeat_q <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         repeat_q <= repeat_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (HOLD_TIME > 0) ^ (REPEAT_TIME > 0);
   assign rpt_fire   = 1'b0;
`endif

   assign press_d   = rise | rpt_fire;
   assign release_d = fall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= btn_i;
         s2_q      <= s1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer: one independent debounce_channel per pin, wiring only.
// Optional auto-repeat press pulses are enabled by defining AUTO_REPEAT_EN.
module multi_button_debouncer
   import debounce_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int DEBOUNCE_TIME = DB_TIME_DEFAULT,
   parameter int HOLD_TIME     = HOLD_TIME_DEFAULT,
   parameter int REPEAT_TIME   = REPEAT_TIME_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] button_in,
   output logic [N_CH-1:0] button_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_TIME(DEBOUNCE_TIME),
         .HOLD_TIME    (HOLD_TIME),
         .REPEAT_TIME  (REPEAT_TIME)
      ) u_ch (
         .clk_i    (clk),
         .rst_i    (reset),
         .btn_i    (button_in[i]),
         .level_o  (button_out[i]),
         .press_o  (press_pulse[i]),
         .release_o(release_pulse[i])
      );
   end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer: reset, bounce, glitch width, simultaneity,
// reset mid-press and (with AUTO_REPEAT_EN) auto-repeat timing.
module tb_multi_button_debouncer;

   localparam int N_CH = 4;
   localparam int DT   = 100;
   localparam int HT   = 1000;
   localparam int RT   = 300;
`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N_CH-1:0] button_in = '0;
   logic [N_CH-1:0] button_out, press_pulse, release_pulse;

   int vectors = 0;
   int miscompares = 0;
   int press_cnt[N_CH] = '{default: 0};
   int release_cnt[N_CH] = '{default: 0};

   multi_button_debouncer #(
      .N_CH(N_CH), .DEBOUNCE_TIME(DT), .HOLD_TIME(HT), .REPEAT_TIME(RT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .button_in    (button_in),
      .button_out   (button_out),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   // clock / pulse tally block
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_CH; i++) begin
         press_cnt[i]   += int'(press_pulse[i]);
         release_cnt[i] += int'(release_pulse[i]);
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset(input logic [N_CH-1:0] pins);
      @(negedge clk);
      reset = 1'b1;
      button_in = pins;
      cyc(2);
      reset = 1'b0;
      cyc(3);
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      button_in = 4'hF;
      for (int i = 0; i < 2; i++) begin
         cyc(1);
         vectors++;
         if ({button_out, press_pulse, release_pulse} !== 12'h000) begin
            miscompares++;
            $display("FAIL t1_in_reset got=%h exp=000", {button_out, press_pulse, release_pulse});
         end
      end
      reset = 1'b0;
      cyc(101);
      vectors++;
      if ({button_out, press_pulse} !== 8'h00) begin
         miscompares++;
         $display("FAIL t1_before_commit got=%h exp=00", {button_out, press_pulse});
      end
      cyc(1);
      vectors++;
      if ({button_out, press_pulse} !== 8'hFF) begin
         miscompares++;
         $display("FAIL t1_commit got=%h exp=ff", {button_out, press_pulse});
      end
      cyc(1);
      vectors++;
      if ({button_out, press_pulse} !== 8'hF0) begin
         miscompares++;
         $display("FAIL t1_pulse_one_cycle got=%h exp=f0", {button_out, press_pulse});
      end
   endtask

   task automatic test_bounce;
      int p0;
      apply_reset('0);
      p0 = press_cnt[0];
      button_in[0] = 1'b1; cyc(5);
      button_in[0] = 1'b0; cyc(3);
      button_in[0] = 1'b1; cyc(2);
      button_in[0] = 1'b0; cyc(4);
      button_in[0] = 1'b1;
      vectors++;
      if (button_out !== 4'h0 || press_cnt[0] != p0) begin
         miscompares++;
         $display("FAIL t2_during_bounce out=%h presses=%0d exp out=0 presses=0",
                  button_out, press_cnt[0] - p0);
      end
      cyc(101);
      vectors++;
      if (button_out[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL t2_early got=%b exp=0", button_out[0]);
      end
      cyc(1);
      vectors++;
      if (button_out !== 4'b0001 || press_pulse !== 4'b0001) begin
         miscompares++;
         $display("FAIL t2_rise out=%b press=%b exp out=0001 press=0001", button_out, press_pulse);
      end
      cyc(20);
      vectors++;
      if (press_cnt[0] - p0 != 1) begin
         miscompares++;
         $display("FAIL t2_press_count got=%0d exp=1", press_cnt[0] - p0);
      end
   endtask

   task automatic test_glitch;
      int p1, r1;
      p1 = press_cnt[1];
      r1 = release_cnt[1];
      button_in[1] = 1'b1; cyc(99);
      button_in[1] = 1'b0; cyc(150);
      vectors++;
      if (button_out[1] !== 1'b0 || press_cnt[1] != p1 || release_cnt[1] != r1) begin
         miscompares++;
         $display("FAIL t3_glitch99 out=%b presses=%0d releases=%0d exp 0/0/0",
                  button_out[1], press_cnt[1] - p1, release_cnt[1] - r1);
      end
      button_in[1] = 1'b1; cyc(100);
      button_in[1] = 1'b0;
      cyc(2);
      vectors++;
      if (button_out[1] !== 1'b1 || press_pulse[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL t3_glitch100_press out=%b press=%b exp 1/1", button_out[1], press_pulse[1]);
      end
      cyc(99);
      vectors++;
      if (button_out[1] !== 1'b1 || release_pulse[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL t3_release_early out=%b rel=%b exp 1/0", button_out[1], release_pulse[1]);
      end
      cyc(1);
      vectors++;
      if (button_out[1] !== 1'b0 || release_pulse[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL t3_release out=%b rel=%b exp 0/1", button_out[1], release_pulse[1]);
      end
      cyc(5);
      vectors++;
      if (press_cnt[1] - p1 != 1 || release_cnt[1] - r1 != 1) begin
         miscompares++;
         $display("FAIL t3_counts presses=%0d releases=%0d exp 1/1",
                  press_cnt[1] - p1, release_cnt[1] - r1);
      end
   endtask

   task automatic test_simultaneous;
      button_in = 4'b1100;
      cyc(101);
      vectors++;
      if (press_pulse !== 4'b0000 || release_pulse !== 4'b0000 || button_out !== 4'b0001) begin
         miscompares++;
         $display("FAIL t4_early press=%b rel=%b out=%b exp 0000/0000/0001",
                  press_pulse, release_pulse, button_out);
      end
      cyc(1);
      vectors++;
      if (press_pulse !== 4'b1100 || release_pulse !== 4'b0001 || button_out !== 4'b1100) begin
         miscompares++;
         $display("FAIL t4_same_edge press=%b rel=%b out=%b exp 1100/0001/1100",
                  press_pulse, release_pulse, button_out);
      end
   endtask

   task automatic test_reset_mid_press;
      apply_reset('0);
      button_in[0] = 1'b1;
      cyc(50);
      vectors++;
      if (button_out !== 4'h0) begin
         miscompares++;
         $display("FAIL t5_pre_reset got=%b exp=0000", button_out);
      end
      reset = 1'b1;
      cyc(2);
      vectors++;
      if ({button_out, press_pulse, release_pulse} !== 12'h000) begin
         miscompares++;
         $display("FAIL t5_in_reset got=%h exp=000", {button_out, press_pulse, release_pulse});
      end
      reset = 1'b0;
      cyc(101);
      vectors++;
      if (button_out[0] !== 1'b0 || press_pulse[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL t5_early out=%b press=%b exp 0/0", button_out[0], press_pulse[0]);
      end
      cyc(1);
      vectors++;
      if (button_out[0] !== 1'b1 || press_pulse[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL t5_fresh_press out=%b press=%b exp 1/1", button_out[0], press_pulse[0]);
      end
   endtask

   task automatic test_auto_repeat;
      int  p0, r0;
      logic exp_p, exp_r;
      apply_reset('0);
      p0 = press_cnt[0];
      r0 = release_cnt[0];
      button_in[0] = 1'b1;
      cyc(102);
      for (int k = 0; k <= 2100; k++) begin
         exp_p = (k == 0) || (AR && (k == HT || k == HT + RT || k == HT + 2 * RT));
         exp_r = (k == 1802);
         vectors++;
         if (press_pulse[0] !== exp_p) begin
            miscompares++;
            $display("FAIL t6_press k=%0d got=%b exp=%b", k, press_pulse[0], exp_p);
         end
         vectors++;
         if (release_pulse[0] !== exp_r) begin
            miscompares++;
            $display("FAIL t6_release k=%0d got=%b exp=%b", k, release_pulse[0], exp_r);
         end
         if (k == 1700) button_in[0] = 1'b0;
         cyc(1);
      end
      vectors++;
      if (press_cnt[0] - p0 != (AR ? 4 : 1) || release_cnt[0] - r0 != 1) begin
         miscompares++;
         $display("FAIL t6_totals presses=%0d releases=%0d exp %0d/1",
                  press_cnt[0] - p0, release_cnt[0] - r0, AR ? 4 : 1);
      end
   endtask

   initial begin
      test_reset();
      apply_reset('0);
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_mid_press();
      test_auto_repeat();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
